// File: rtl/async_fifo_pkg.sv
// Shared defaults and sizing helpers for the single-clock FIFO.
// Thresholds are expressed as occupancy levels compared against the pointer difference.
package async_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 4;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int almost_full_level(input int depth);
        return depth - 1;
    endfunction

    localparam int DEF_DEPTH             = fifo_depth(DEF_ADDR_WIDTH);
    localparam int DEF_ALMOST_FULL_LEVEL = almost_full_level(DEF_DEPTH);
    localparam int ALMOST_EMPTY_LEVEL    = 1;

endpackage

// File: rtl/async_fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register resets to zero and holds its value when no read is issued.
module async_fifo_mem
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO with wrap-bit pointers, registered read port and early-warning flags.
// Flags come straight from the registered pointers, so they lag an accepted access by one edge.
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_en,
    output logic                  empty,
    output logic                  almost_empty
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH+1)'(almost_full_level(DEPTH));
    localparam logic [ADDR_WIDTH:0] AE_LEVEL = (ADDR_WIDTH+1)'(ALMOST_EMPTY_LEVEL);

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic                rd_valid_q, rd_valid_d;
    logic [ADDR_WIDTH:0] count;
    logic                wr_accept;
    logic                rd_accept;

    assign count        = wr_ptr_q - rd_ptr_q;
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                          (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    assign almost_full  = (count >= AF_LEVEL);
    assign almost_empty = (count <= AE_LEVEL);

    // Both requests are judged against pre-edge flags; a reset cycle swallows them.
    always_comb begin
        wr_accept  = wr_en && !full && !rst;
        rd_accept  = rd_en && !empty && !rst;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = rd_accept;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_valid = rd_valid_q;

    async_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_async_fifo.sv
// Bench for async_fifo: fixed vector table, directed corner sequences and a random run,
// all scored against a queue model of the FIFO's occupancy and read-out order.
module tb_async_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] wr_data = '0;
    logic        wr_en = 1'b0;
    logic        full, almost_full;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_en = 1'b0;
    logic        empty, almost_empty;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] mq[$];
    logic [15:0] m_rd = '0;
    logic        m_rv = 1'b0;

    always #5 clk = ~clk;

    async_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .full         (full),
        .almost_full  (almost_full),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_en        (rd_en),
        .empty        (empty),
        .almost_empty (almost_empty)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_model();
        int sz;
        sz = mq.size();
        chk("m_empty",    32'(empty),        32'(sz == 0));
        chk("m_full",     32'(full),         32'(sz == 16));
        chk("m_aempty",   32'(almost_empty), 32'(sz <= 1));
        chk("m_afull",    32'(almost_full),  32'(sz >= 15));
        chk("m_rd_valid", 32'(rd_valid),     32'(m_rv));
        chk("m_rd_data",  32'(rd_data),      32'(m_rd));
    endtask

    // One clock: drive at negedge, advance the model, sample just after the rising edge.
    task automatic cycle(input logic r_st, input logic w, input logic r, input logic [15:0] d);
        logic rd_ok, wr_ok;
        @(negedge clk);
        rst = r_st; wr_en = w; rd_en = r; wr_data = d;
        if (r_st) begin
            mq.delete();
            m_rd = '0;
            m_rv = 1'b0;
        end else begin
            rd_ok = r && (mq.size() > 0);
            wr_ok = w && (mq.size() < 16);
            m_rv  = rd_ok;
            if (rd_ok) m_rd = mq.pop_front();
            if (wr_ok) mq.push_back(d);
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        logic        w, r;
        logic [15:0] d;
        logic        e, f, ae, af, rv;
        logic [15:0] rd;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 16'h00A1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 16'h00A2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[2] = '{1'b1, 1'b1, 16'h00A3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00A1};
        tbl[3] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00A2};
        tbl[4] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00A2};
        tbl[5] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00A3};
        tbl[6] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00A3};
        tbl[7] = '{1'b1, 1'b1, 16'h00B1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00A3};
        tbl[8] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00B1};
        tbl[9] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00B1};

        // Reset held for two cycles
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);
        chk("rst_empty",    32'(empty),        32'd1);
        chk("rst_aempty",   32'(almost_empty), 32'd1);
        chk("rst_full",     32'(full),         32'd0);
        chk("rst_afull",    32'(almost_full),  32'd0);
        chk("rst_rd_valid", 32'(rd_valid),     32'd0);
        chk("rst_rd_data",  32'(rd_data),      32'd0);

        // Fixed vector table
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, tbl[i].w, tbl[i].r, tbl[i].d);
            chk($sformatf("tbl%0d_empty", i),  32'(empty),        32'(tbl[i].e));
            chk($sformatf("tbl%0d_full", i),   32'(full),         32'(tbl[i].f));
            chk($sformatf("tbl%0d_aempty", i), 32'(almost_empty), 32'(tbl[i].ae));
            chk($sformatf("tbl%0d_afull", i),  32'(almost_full),  32'(tbl[i].af));
            chk($sformatf("tbl%0d_rv", i),     32'(rd_valid),     32'(tbl[i].rv));
            chk($sformatf("tbl%0d_rd", i),     32'(rd_data),      32'(tbl[i].rd));
        end

        // Overfill with 1..20
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 16'(i));
            chk($sformatf("fill%0d_afull", i), 32'(almost_full), 32'(i >= 15));
            chk($sformatf("fill%0d_full", i),  32'(full),        32'(i >= 16));
        end

        // Drain with 25 read requests
        for (int j = 1; j <= 25; j++) begin
            cycle(1'b0, 1'b0, 1'b1, 16'h0);
            if (j <= 16) begin
                chk($sformatf("drain%0d_rv", j), 32'(rd_valid), 32'd1);
                chk($sformatf("drain%0d_rd", j), 32'(rd_data),  32'(j));
            end else begin
                chk($sformatf("drain%0d_rv", j), 32'(rd_valid), 32'd0);
                chk($sformatf("drain%0d_rd", j), 32'(rd_data),  32'd16);
            end
            chk($sformatf("drain%0d_aempty", j), 32'(almost_empty), 32'(j >= 15));
            chk($sformatf("drain%0d_empty", j),  32'(empty),        32'(j >= 16));
        end

        // Eight stored, then 40 cycles of simultaneous write+read through the wrap
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 1'b0, 16'(100 + k));
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 16'(200 + i));
            chk($sformatf("sim%0d_rv", i), 32'(rd_valid), 32'd1);
            chk($sformatf("sim%0d_rd", i), 32'(rd_data),
                (i < 8) ? 32'(100 + i) : 32'(200 + i - 8));
            chk($sformatf("sim%0d_empty", i), 32'(empty), 32'd0);
            chk($sformatf("sim%0d_afull", i), 32'(almost_full), 32'd0);
        end
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b1, 16'h0);
        chk("sim_drained", 32'(empty), 32'd1);

        // Full collision: only the read goes through
        for (int k = 0; k < 16; k++) cycle(1'b0, 1'b1, 1'b0, 16'(300 + k));
        chk("fc_full_before", 32'(full), 32'd1);
        cycle(1'b0, 1'b1, 1'b1, 16'd999);
        chk("fc_rv",    32'(rd_valid),    32'd1);
        chk("fc_rd",    32'(rd_data),     32'd300);
        chk("fc_full",  32'(full),        32'd0);
        chk("fc_afull", 32'(almost_full), 32'd1);
        for (int k = 0; k < 15; k++) begin
            cycle(1'b0, 1'b0, 1'b1, 16'h0);
            chk($sformatf("fc_drain%0d", k), 32'(rd_data), 32'(301 + k));
        end

        // Empty collision: only the write goes through
        cycle(1'b0, 1'b1, 1'b1, 16'd555);
        chk("ec_rv",     32'(rd_valid),     32'd0);
        chk("ec_empty",  32'(empty),        32'd0);
        chk("ec_aempty", 32'(almost_empty), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 16'h0);
        chk("ec_rd", 32'(rd_data), 32'd555);

        // Reset in the middle of operation
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0, 16'(700 + k));
        cycle(1'b1, 1'b1, 1'b1, 16'd777);
        chk("mr_empty", 32'(empty), 32'd1);
        chk("mr_rd",    32'(rd_data), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 16'h0);
        chk("mr_rv",    32'(rd_valid), 32'd0);
        chk("mr_empty2", 32'(empty), 32'd1);

        // Random traffic with phases biased towards filling and draining
        for (int i = 0; i < 800; i++) begin
            logic w, r, rs;
            int bias;
            bias = ((i / 100) % 2 == 0) ? 75 : 25;
            w  = ($urandom_range(0, 99) < bias);
            r  = ($urandom_range(0, 99) < (100 - bias));
            rs = ($urandom_range(0, 199) == 0);
            cycle(rs, w, r, 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
